// File: rtl/instr_fetch.sv
// Instruction fetch stage for the 5-cycle-per-instruction core: one memory
// request per instruction window, fetched word held in an instruction register.
module instr_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_addr,
    input  logic        can_write,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic        fetch_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE     = 2'b00;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b01;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DONE  = 2'b10,
        ABORT = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [1:0]  fault_cause_q, fault_cause_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        misaligned_s;

    // A word fetch must be 4-byte aligned; otherwise no request is issued at all.
    assign misaligned_s = (i_addr[1:0] != 2'b00);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; misalignment outranks the acknowledge.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = REQ;
            REQ: begin
                if (misaligned_s) begin
                    state_d = DONE;
                end else if (imem_ack && !can_write) begin
                    state_d = DONE;
                end else if (!imem_ack && can_write) begin
                    state_d = ABORT;
                end else begin
                    // Includes the late acknowledge: stay and request the next address.
                    state_d = REQ;
                end
            end
            DONE: begin
                if (can_write) begin
                    state_d = REQ;
                end else begin
                    state_d = DONE;
                end
            end
            ABORT:   state_d = REQ;
            default: state_d = IDLE;
        endcase
    end

    // Memory interface outputs decoded from the state.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = i_addr;
        case (state_q)
            REQ:     imem_req = !misaligned_s;
            default: imem_req = 1'b0;
        endcase
    end

    // Instruction register, status and counter updates.
    always_comb begin
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        fetch_fault_d = fetch_fault_q;
        fault_cause_d = fault_cause_q;
        fetch_count_d = fetch_count_q;
        case (state_q)
            REQ: begin
                if (misaligned_s) begin
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b1;
                    fetch_fault_d = 1'b1;
                    fault_cause_d = CAUSE_MISALIGN;
                end else if (imem_ack) begin
                    // A late ack still loads the word but leaves the window unvalidated.
                    instr_d       = imem_rdata;
                    instr_valid_d = !can_write;
                    fetch_count_d = fetch_count_q + 32'd1;
                end else if (can_write) begin
                    instr_d       = NOP_INSTR;
                    instr_valid_d = 1'b0;
                    fetch_fault_d = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end else begin
                    instr_d = instr_q;
                end
            end
            DONE: begin
                if (can_write) begin
                    instr_valid_d = 1'b0;
                end else begin
                    instr_valid_d = instr_valid_q;
                end
            end
            default: instr_d = instr_q;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fault_cause_q <= CAUSE_NONE;
            fetch_count_q <= 32'd0;
        end else begin
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            fetch_fault_q <= fetch_fault_d;
            fault_cause_q <= fault_cause_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign fetch_fault = fetch_fault_q;
    assign fault_cause = fault_cause_q;
    assign fetch_count = fetch_count_q;
    assign opcode      = instr_q[6:0];
    assign rd          = instr_q[11:7];
    assign funct3      = instr_q[14:12];
    assign rs1         = instr_q[19:15];
    assign rs2         = instr_q[24:20];
    assign funct7      = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed testbench for instr_fetch: emulates the PC's 5-cycle windows and
// an instruction memory with hand-placed acknowledges.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_addr;
    logic        can_write;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic        fetch_fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (i_addr),
        .can_write   (can_write),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause),
        .fetch_count (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cw, input logic ack, input logic [31:0] rdata);
        can_write  = cw;
        imem_ack   = ack;
        imem_rdata = rdata;
    endtask

    // Leaves the bench at c0 of the first window (first REQ cycle).
    task automatic do_reset(input logic [31:0] addr);
        drive(1'b0, 1'b0, 32'd0);
        reset  = 1'b0;
        i_addr = addr;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    // c4 of a window: can_write high, then the PC presents the next address.
    task automatic end_window(input logic [31:0] next_addr);
        drive(1'b1, 1'b0, 32'd0);
        tick();
        i_addr = next_addr;
        drive(1'b0, 1'b0, 32'd0);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'd0);
        i_addr = 32'd0;
        reset  = 1'b0;
        tick();
        tick();
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (instr !== NOP) begin failures++; $display("FAIL reset_instr got %h want %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got %b want 0", fetch_fault); end
        checks++; if (fault_cause !== 2'b00) begin failures++; $display("FAIL reset_cause got %b want 00", fault_cause); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL reset_count got %0d want 0", fetch_count); end
        reset = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL idle_req got %b want 0", imem_req); end
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL first_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin failures++; $display("FAIL first_addr got %h want 0", imem_addr); end
        drive(1'b0, 1'b1, 32'h0050_0093);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (instr !== 32'h0050_0093) begin failures++; $display("FAIL first_instr got %h want 00500093", instr); end
        checks++; if (opcode !== 7'h13) begin failures++; $display("FAIL first_opcode got %h want 13", opcode); end
        checks++; if (rd !== 5'd1) begin failures++; $display("FAIL first_rd got %0d want 1", rd); end
        checks++; if (funct3 !== 3'd0) begin failures++; $display("FAIL first_funct3 got %0d want 0", funct3); end
        checks++; if (rs1 !== 5'd0) begin failures++; $display("FAIL first_rs1 got %0d want 0", rs1); end
        checks++; if (rs2 !== 5'd5) begin failures++; $display("FAIL first_rs2 got %0d want 5", rs2); end
        checks++; if (funct7 !== 7'd0) begin failures++; $display("FAIL first_funct7 got %0d want 0", funct7); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL first_valid got %b want 1", instr_valid); end
        checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL first_count got %0d want 1", fetch_count); end
        repeat (3) tick();
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL c4_valid got %b want 1", instr_valid); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL done_req got %b want 0", imem_req); end
        end_window(32'd4);
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL c0_valid got %b want 0", instr_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        do_reset(32'd0);
        for (int k = 0; k < 5; k++) begin
            data = 32'h1000_0000 + 32'(k);
            checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL b2b_req[%0d] got %b want 1", k, imem_req); end
            checks++; if (imem_addr !== 32'(k * 4)) begin failures++; $display("FAIL b2b_addr[%0d] got %h want %h", k, imem_addr, 32'(k * 4)); end
            tick();
            tick();
            drive(1'b0, 1'b1, data);
            tick();
            drive(1'b0, 1'b0, 32'd0);
            checks++; if (instr !== data) begin failures++; $display("FAIL b2b_instr[%0d] got %h want %h", k, instr, data); end
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got %b want 1", k, instr_valid); end
            tick();
            end_window(32'((k + 1) * 4));
        end
        checks++; if (fetch_count !== 32'd5) begin failures++; $display("FAIL b2b_count got %0d want 5", fetch_count); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL b2b_fault got %b want 0", fetch_fault); end
    endtask

    task automatic test_timeout();
        do_reset(32'h0000_0100);
        repeat (4) tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL to_req_c4 got %b want 1", imem_req); end
        end_window(32'h0000_0104);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL to_abort_req got %b want 0", imem_req); end
        checks++; if (instr !== NOP) begin failures++; $display("FAIL to_instr got %h want %h", instr, NOP); end
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL to_fault got %b want 1", fetch_fault); end
        checks++; if (fault_cause !== 2'b01) begin failures++; $display("FAIL to_cause got %b want 01", fault_cause); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL to_valid got %b want 0", instr_valid); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL to_count got %0d want 0", fetch_count); end
        tick();
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL to_c1_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0000_0104) begin failures++; $display("FAIL to_c1_addr got %h want 00000104", imem_addr); end
        drive(1'b0, 1'b1, 32'h00A0_0113);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (instr !== 32'h00A0_0113) begin failures++; $display("FAIL to_next_instr got %h want 00a00113", instr); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL to_next_valid got %b want 1", instr_valid); end
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL to_sticky got %b want 1", fetch_fault); end
        checks++; if (fault_cause !== 2'b01) begin failures++; $display("FAIL to_cause_kept got %b want 01", fault_cause); end
    endtask

    task automatic test_misaligned();
        do_reset(32'h0000_0006);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL mis_req got %b want 0", imem_req); end
        drive(1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (instr !== NOP) begin failures++; $display("FAIL mis_instr got %h want %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL mis_valid got %b want 1", instr_valid); end
        checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL mis_fault got %b want 1", fetch_fault); end
        checks++; if (fault_cause !== 2'b10) begin failures++; $display("FAIL mis_cause got %b want 10", fault_cause); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL mis_count got %0d want 0", fetch_count); end
    endtask

    task automatic test_late_ack();
        do_reset(32'h0000_0200);
        repeat (4) tick();
        drive(1'b1, 1'b1, 32'h00A0_0113);
        tick();
        i_addr = 32'h0000_0204;
        drive(1'b0, 1'b0, 32'd0);
        #1;
        checks++; if (instr !== 32'h00A0_0113) begin failures++; $display("FAIL late_instr got %h want 00a00113", instr); end
        checks++; if (rd !== 5'd2) begin failures++; $display("FAIL late_rd got %0d want 2", rd); end
        checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL late_count got %0d want 1", fetch_count); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL late_fault got %b want 0", fetch_fault); end
        checks++; if (fault_cause !== 2'b00) begin failures++; $display("FAIL late_cause got %b want 00", fault_cause); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL late_valid got %b want 0", instr_valid); end
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL late_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0000_0204) begin failures++; $display("FAIL late_addr got %h want 00000204", imem_addr); end
        drive(1'b0, 1'b1, 32'h00C0_0193);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (instr !== 32'h00C0_0193) begin failures++; $display("FAIL late_next_instr got %h want 00c00193", instr); end
        checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL late_next_valid got %b want 1", instr_valid); end
        checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL late_next_count got %0d want 2", fetch_count); end
    endtask

    task automatic test_async_reset();
        do_reset(32'h0000_0300);
        drive(1'b0, 1'b1, 32'h0050_0093);
        tick();
        drive(1'b0, 1'b0, 32'd0);
        checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL ar_pre_count got %0d want 1", fetch_count); end
        repeat (3) tick();
        end_window(32'h0000_0304);
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL ar_pre_req got %b want 1", imem_req); end
        #1;
        reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL ar_req got %b want 0", imem_req); end
        checks++; if (instr !== NOP) begin failures++; $display("FAIL ar_instr got %h want %h", instr, NOP); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got %b want 0", instr_valid); end
        checks++; if (fetch_count !== 32'd0) begin failures++; $display("FAIL ar_count got %0d want 0", fetch_count); end
        checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL ar_fault got %b want 0", fetch_fault); end
        checks++; if (fault_cause !== 2'b00) begin failures++; $display("FAIL ar_cause got %b want 00", fault_cause); end
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        i_addr     = 32'd0;
        can_write  = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        test_reset();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_late_ack();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
